// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one signed multiplier and one accumulator walk NTAPS taps per
// accepted sample; the full-precision sum is registered straight into o_data.
module fir_mac_serial #(
    parameter int NB_DATA  = 8,
    parameter int NBF_DATA = 6,
    parameter int NB_COEF  = 8,
    parameter int NBF_COEF = 7,
    parameter int NTAPS    = 8,
    parameter int NB_ADDR  = 3,
    parameter int NB_OUT   = 19,
    parameter int NBF_OUT  = 13
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_valid,
    input  logic signed [NB_DATA-1:0] i_data,
    output logic                      o_ready,
    input  logic                      i_coef_we,
    input  logic        [NB_ADDR-1:0] i_coef_addr,
    input  logic signed [NB_COEF-1:0] i_coef_data,
    output logic                      o_valid,
    output logic signed [NB_OUT-1:0]  o_data
);

    localparam int NB_PROD = NB_DATA + NB_COEF;

    if (((1 << NB_ADDR) != NTAPS) || (NTAPS < 2) ||
        (NB_OUT != NB_DATA + NB_COEF + NB_ADDR) ||
        (NBF_OUT != NBF_DATA + NBF_COEF)) begin : g_param_check
        $error("fir_mac_serial: inconsistent width/tap parameters");
    end

    typedef enum logic {
        IDLE,
        MAC
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic                        ready_next;
    logic                        valid_next;
    logic        [NB_ADDR-1:0]   cnt;
    logic signed [NB_DATA-1:0]   x [NTAPS];
    logic signed [NB_COEF-1:0]   c [NTAPS];
    logic signed [NB_OUT-1:0]    acc;
    logic signed [NB_PROD-1:0]   prod;
    logic signed [NB_OUT-1:0]    sum;
    logic                        accept;
    logic                        last;

    // Guard bits above the product make every accumulation overflow-free.
    function automatic logic signed [NB_OUT-1:0] sext_prod(input logic signed [NB_PROD-1:0] p);
        return {{(NB_OUT - NB_PROD){p[NB_PROD-1]}}, p};
    endfunction

    assign accept = (state == IDLE) && o_ready && i_valid;
    assign last   = (state == MAC) && (cnt == NB_ADDR'(NTAPS - 1));
    assign prod   = x[cnt] * c[cnt];
    assign sum    = acc + sext_prod(prod);

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            o_ready <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            state   <= state_next;
            o_ready <= ready_next;
            o_valid <= valid_next;
        end
    end

    // o_ready comes up one edge after reset release, then tracks IDLE exactly.
    always_comb begin
        state_next = state;
        ready_next = o_ready;
        valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = MAC;
                    ready_next = 1'b0;
                end else begin
                    ready_next = 1'b1;
                end
            end
            MAC: begin
                if (last) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                    valid_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                ready_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
            acc    <= '0;
            cnt    <= '0;
            o_data <= '0;
        end else begin
            // Coefficients are read from E1 onward, so a write on the accept edge is seen.
            if (o_ready && i_coef_we) begin
                c[i_coef_addr] <= i_coef_data;
            end
            if (accept) begin
                for (int k = NTAPS - 1; k >= 1; k--) begin
                    x[k] <= x[k-1];
                end
                x[0] <= i_data;
                acc  <= '0;
                cnt  <= '0;
            end else if (state == MAC) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
                if (last) begin
                    o_data <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_serial.sv
// Randomised and directed bench for fir_mac_serial; a queue-based scoreboard checks each
// o_valid result against a plain-arithmetic FIR model.
module tb_fir_mac_serial;

    localparam int NB_DATA = 8;
    localparam int NB_COEF = 8;
    localparam int NTAPS   = 8;
    localparam int NB_ADDR = 3;
    localparam int NB_OUT  = 19;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                valid_in;
    logic [NB_DATA-1:0]  data_in;
    logic                ready;
    logic                coef_we;
    logic [NB_ADDR-1:0]  coef_addr;
    logic [NB_COEF-1:0]  coef_data;
    logic                valid_out;
    logic [NB_OUT-1:0]   data_out;

    always #5 clock = ~clock;

    fir_mac_serial dut (
        .i_clock     (clock),
        .i_reset_n   (reset_n),
        .i_valid     (valid_in),
        .i_data      (data_in),
        .o_ready     (ready),
        .i_coef_we   (coef_we),
        .i_coef_addr (coef_addr),
        .i_coef_data (coef_data),
        .o_valid     (valid_out),
        .o_data      (data_out)
    );

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int obs_q[$];
    int coef_m[NTAPS];
    int hist_m[NTAPS];

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference model: direct convolution over the last NTAPS accepted samples.
    function automatic void model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            coef_m[k] = 0;
            hist_m[k] = 0;
        end
        exp_q.delete();
    endfunction

    function automatic void model_accept(input int s);
        int acc;
        for (int k = NTAPS - 1; k >= 1; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = s;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) acc += hist_m[k] * coef_m[k];
        exp_q.push_back(acc);
    endfunction

    always @(negedge clock) begin : monitor
        int e;
        if (reset_n === 1'b1 && valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got o_valid=1 o_data=%0d, want no result",
                         $signed(data_out));
            end else begin
                e = exp_q.pop_front();
                check("result", $signed(data_out), e);
                obs_q.push_back(int'($signed(data_out)));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got o_ready=%b, want 1 within 200 cycles", ready);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: got %0d pending results, want 0", exp_q.size());
            exp_q.delete();
        end
        wait_ready();
    endtask

    task automatic send(input logic [NB_DATA-1:0] v);
        wait_ready();
        valid_in = 1'b1;
        data_in  = v;
        model_accept($signed(v));
        @(negedge clock);
        valid_in = 1'b0;
    endtask

    task automatic coef_write(input logic [NB_ADDR-1:0] a, input logic [NB_COEF-1:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        if (ready === 1'b1) coef_m[a] = $signed(d);
        @(negedge clock);
        coef_we = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        model_reset();
        repeat (cycles) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int low_cnt;
        int vpos;
        int vcnt;
        int acc_cyc[$];
        int imp[10];
        imp = '{64, 128, 192, 256, 320, 384, 448, 512, 0, 0};

        valid_in  = 1'b0;
        data_in   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        reset_n   = 1'b0;
        model_reset();

        // 1. reset values and accept-to-result timing
        repeat (3) begin
            @(negedge clock);
            check("reset_ready", ready, 0);
            check("reset_valid", valid_out, 0);
            check("reset_data", $signed(data_out), 0);
        end
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_after_release", ready, 1);
        valid_in = 1'b1;
        data_in  = 8'h40;
        model_accept(64);
        @(negedge clock);
        valid_in = 1'b0;
        low_cnt = 0;
        vpos = 0;
        vcnt = 0;
        for (int n = 1; n <= 12; n++) begin
            if (ready !== 1'b1) low_cnt++;
            if (valid_out === 1'b1) begin
                vcnt++;
                if (vpos == 0) vpos = n;
            end
            @(negedge clock);
        end
        check("ready_low_cycles", low_cnt, 8);
        check("valid_cycle", vpos, 9);
        check("valid_width", vcnt, 1);
        drain();

        // 2. impulse response with c[k]=k+1
        do_reset(2);
        obs_q.delete();
        for (int k = 0; k < NTAPS; k++) coef_write(NB_ADDR'(k), NB_COEF'(k + 1));
        send(8'h40);
        repeat (9) send(8'h00);
        drain();
        check("impulse_count", obs_q.size(), 10);
        for (int i = 0; i < 10 && i < obs_q.size(); i++) check("impulse", obs_q[i], imp[i]);

        // 3. worst-case magnitude
        obs_q.delete();
        for (int k = 0; k < NTAPS; k++) coef_write(NB_ADDR'(k), 8'h80);
        repeat (8) send(8'h80);
        drain();
        check("worst_count", obs_q.size(), 8);
        if (obs_q.size() == 8) check("worst_value", obs_q[7], 131072);
        check("worst_sign", data_out[NB_OUT-1], 0);

        // 4. back-pressure: i_valid held with an incrementing sample
        valid_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data_in = NB_DATA'(i + 1);
            if (ready === 1'b1) begin
                model_accept($signed(data_in));
                acc_cyc.push_back(i);
            end
            @(negedge clock);
        end
        valid_in = 1'b0;
        drain();
        check("bp_accepts", acc_cyc.size(), 5);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("bp_period", acc_cyc[i] - acc_cyc[i-1], 9);

        // 5. coefficient write while busy is dropped; while idle it lands
        send(8'h20);
        repeat (2) @(negedge clock);
        coef_write(3'd0, 8'h7F);
        drain();
        send(8'h30);
        drain();
        coef_write(3'd0, 8'h7F);
        send(8'h11);
        drain();
        for (int r = 0; r < 4; r++) begin
            wait_ready();
            coef_we   = 1'b1;
            coef_addr = NB_ADDR'($urandom_range(0, NTAPS - 1));
            coef_data = NB_COEF'($urandom);
            valid_in  = 1'b1;
            data_in   = NB_DATA'($urandom);
            coef_m[coef_addr] = $signed(coef_data);
            model_accept($signed(data_in));
            @(negedge clock);
            coef_we  = 1'b0;
            valid_in = 1'b0;
        end
        drain();
        repeat (12) send(NB_DATA'($urandom));
        drain();

        // 6. reset at the fourth MAC edge
        send(8'h40);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        vcnt = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clock);
            if (valid_out === 1'b1) vcnt++;
        end
        check("abort_no_valid", vcnt, 0);
        check("abort_data", $signed(data_out), 0);
        obs_q.delete();
        send(8'h40);
        drain();
        check("abort_coefs_zero", (obs_q.size() > 0) ? obs_q[0] : -1, 0);
        for (int k = 0; k < NTAPS; k++) coef_write(NB_ADDR'(k), NB_COEF'(k + 1));
        send(8'h00);
        drain();

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_mac_serial.md
Name: fir_mac_serial

Overview:
- Time-multiplexed FIR filter: one signed multiplier and one accumulator, cycled over NTAPS taps per input sample.
- Produces a full-precision result that feeds the downstream saturation/rounding stage directly. That stage is configured with NB_XI=NB_OUT and NBF_XI=NBF_OUT.
- Coefficients are runtime-loadable through a simple write port.
- One sample is accepted per NTAPS+1 clock cycles.

Parameters:
- NB_DATA, 8: input sample width, signed.
- NBF_DATA, 6: fractional bits of the input sample.
- NB_COEF, 8: coefficient width, signed.
- NBF_COEF, 7: fractional bits of each coefficient.
- NTAPS, 8: number of taps; must be a power of 2 and at least 2.
- NB_ADDR, 3: coefficient address width, equal to log2(NTAPS).
- NB_OUT, 19: output width, equal to NB_DATA+NB_COEF+NB_ADDR.
- NBF_OUT, 13: output fractional bits, equal to NBF_DATA+NBF_COEF.

Ports:
- i_clock  in  1  system clock; all state updates on the rising edge.
- i_reset_n  in  1  synchronous reset, active-low.
- i_valid  in  1  input sample valid.
- i_data  in  NB_DATA  input sample, signed S(NB_DATA,NBF_DATA).
- o_ready  out  1  block can accept a sample or a coefficient write.
- i_coef_we  in  1  coefficient write enable.
- i_coef_addr  in  NB_ADDR  tap index to write.
- i_coef_data  in  NB_COEF  coefficient value, signed.
- o_valid  out  1  one-cycle pulse: o_data holds a new result.
- o_data  out  NB_OUT  filter output, signed S(NB_OUT,NBF_OUT), registered.

Behaviour:
- Reset (i_reset_n low at a rising edge):
  - state=IDLE; delay line x[0..NTAPS-1]=0; coefficients c[0..NTAPS-1]=0; accumulator=0; tap counter=0.
  - o_data=0, o_valid=0, o_ready=0.
  - o_ready rises to 1 at the first edge after reset is released.
- Reset mid-operation aborts any accumulation. No o_valid is produced for the aborted sample, and the delay line is cleared.
- States: IDLE, MAC. o_ready is registered and equals 1 exactly while state=IDLE.
- IDLE, at an edge with i_valid=1 and o_ready=1 (accept edge E0):
  - shift the delay line: x[k]<=x[k-1] for k≥1, x[0]<=i_data;
  - accumulator<=0, counter<=0, o_ready<=0, state<=MAC.
- IDLE with i_valid=0: hold all state.
- MAC, edge Ek for k=1..NTAPS:
  - accumulator += sign_extend(x[k-1]*c[k-1]);
  - counter increments.
- At edge E_NTAPS, the final sum is written directly into o_data. At that same edge: o_valid<=1, o_ready<=1, state<=IDLE.
- Latency: o_valid is high in the cycle following E_NTAPS, i.e. NTAPS cycles after the accept edge.
- o_valid is high for exactly one cycle. o_data holds its value until the next result or reset.
- i_valid while in MAC (o_ready=0) is ignored. The sample is not stored; the upstream must hold it.
- Back-to-back operation: i_valid may be accepted in the same cycle that o_valid=1. The minimum accept period is NTAPS+1 cycles.
- Coefficient write:
  - performed at an edge with i_coef_we=1 and o_ready=1, writing c[i_coef_addr]<=i_coef_data;
  - dropped silently when o_ready=0;
  - if it coincides with a sample accept, the write lands first and is used by that sample's MAC.
- Arithmetic:
  - signed two's complement throughout; full-precision product of NB_DATA+NB_COEF bits;
  - each product sign-extended to NB_OUT before accumulation;
  - NB_ADDR guard bits guarantee no overflow, so no wrap can occur for any input/coefficient combination.
- No rounding or truncation is done here; that is the downstream stage's job.

Test Plan:
1. Reset then latency:
   - Stimulus: hold i_reset_n low 3 cycles, release; check outputs, then accept a sample and watch o_ready/o_valid timing.
   - Required: o_data=0, o_valid=0; o_ready=0 during reset and 1 one cycle after release; o_ready low exactly 8 cycles after the accept; o_valid pulses in cycle 8 after the accept edge.
2. Impulse response:
   - Stimulus: load c[k]=k+1 (raw); feed 0x40 (1.0) followed by 9 zero samples, each as soon as o_ready=1.
   - Required: o_data raw = 64, 128, 192, 256, 320, 384, 448, 512, 0, 0.
3. Worst-case magnitude:
   - Stimulus: all c[k]=0x80 (-1.0); feed eight samples of 0x80 (-2.0).
   - Required: eighth output = +131072 (0x20000), no overflow, sign bit 0.
4. Back-pressure:
   - Stimulus: hold i_valid=1 continuously with an incrementing i_data.
   - Required: samples accepted only on edges where o_ready=1, exactly every 9 cycles; skipped values never enter the delay line.
5. Coefficient write during MAC:
   - Stimulus: write c[0]=0x7F while o_ready=0.
   - Required: write dropped; the next result uses the old c[0]. The same write issued while o_ready=1 takes effect.
6. Mid-MAC reset:
   - Stimulus: assert i_reset_n low for 1 cycle at the 4th MAC cycle.
   - Required: no o_valid for that sample; delay line and coefficients read back as zero (next impulse yields o_data=0).
